// File: rtl/siso_shift_ctrl_pkg.sv
// Shared types and constants for the serial shift controller.
// Define SISO_SHIFT_CTRL_PARITY_EN to add the trailing even-parity state.
package siso_shift_ctrl_pkg;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;

`ifdef SISO_SHIFT_CTRL_PARITY_EN
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1
   } state_t;
`endif

endpackage

// File: rtl/siso_shreg.sv
// Parallel-load shift register with synchronous clear; dir=0 shifts toward
// the MSB end, dir=1 shifts toward the LSB end, zero-filling the vacated bit.
module siso_shreg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             load,
   input  logic             shift,
   input  logic             dir,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_reg;

   always_ff @(posedge clk) begin
      if (clr)
         q_reg <= '0;
      else if (load)
         q_reg <= d;
      else if (shift)
         q_reg <= dir ? {1'b0, q_reg[WIDTH-1:1]} : {q_reg[WIDTH-2:0], 1'b0};
   end

   assign q = q_reg;

endmodule

// File: rtl/siso_shift_ctrl.sv
// Parallel-in, serial-out frame controller with valid/ready intake and abort.
// Define SISO_SHIFT_CTRL_PARITY_EN to append an even-parity bit to each frame.
module siso_shift_ctrl
   import siso_shift_ctrl_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   input  logic             abort,
   output logic             sout,
   output logic             shift_en,
   output logic             busy,
   output logic             done
);

   localparam int             CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
      $error("siso_shift_ctrl: WIDTH out of range");
   end

   state_t           state_reg;
   logic [CW-1:0]    cnt_reg;
   logic             done_reg;
   logic [WIDTH-1:0] shreg_q;
   logic             handshake;
   logic             in_shift;

   assign s_ready   = (state_reg == IDLE) && !abort && rst_n;
   assign handshake = s_valid && s_ready;
   assign in_shift  = (state_reg == SHIFT);

   siso_shreg #(.WIDTH(WIDTH)) u_shreg (
      .clk   (clk),
      .clr   (!rst_n || abort),
      .load  (handshake),
      .shift (in_shift),
      .dir   (LSB_FIRST),
      .d     (s_data),
      .q     (shreg_q)
   );

`ifdef SISO_SHIFT_CTRL_PARITY_EN
   logic parity_reg;
   logic in_parity;

   assign in_parity = (state_reg == PARITY);

   // Parity is taken from the word as captured, since the shifter empties it.
   always_ff @(posedge clk) begin
      if (!rst_n || abort)
         parity_reg <= 1'b0;
      else if (handshake)
         parity_reg <= ^s_data;
   end

   assign sout     = in_shift  ? (LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1]) :
                     in_parity ? parity_reg : 1'b0;
   assign shift_en = in_shift || in_parity;
`else
   assign sout     = in_shift ? (LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1]) : 1'b0;
   assign shift_en = in_shift;
`endif

   assign busy = shift_en;
   assign done = done_reg;

   always_ff @(posedge clk) begin
      if (!rst_n || abort) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (handshake) begin
                  state_reg <= SHIFT;
                  cnt_reg   <= '0;
               end
            end
            SHIFT: begin
               if (cnt_reg == LAST) begin
                  cnt_reg <= '0;
`ifdef SISO_SHIFT_CTRL_PARITY_EN
                  state_reg <= PARITY;
`else
                  state_reg <= IDLE;
                  done_reg  <= 1'b1;
`endif
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
`ifdef SISO_SHIFT_CTRL_PARITY_EN
            PARITY: begin
               state_reg <= IDLE;
               done_reg  <= 1'b1;
            end
`endif
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// Directed bench: an MSB-first and an LSB-first instance share all stimulus.
module tb_siso_shift_ctrl;

`ifdef SISO_SHIFT_CTRL_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       s_valid;
   logic [7:0] s_data;
   logic       abort;
   logic       s_ready, sout, shift_en, busy, done;
   logic       s_ready_l, sout_l, shift_en_l, busy_l, done_l;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   siso_shift_ctrl #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .abort(abort), .sout(sout), .shift_en(shift_en),
      .busy(busy), .done(done)
   );

   siso_shift_ctrl #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_l),
      .s_data(s_data), .abort(abort), .sout(sout_l), .shift_en(shift_en_l),
      .busy(busy_l), .done(done_l)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_chk(input string tag, input logic exp_done);
      chk({tag, "_busy"},     busy,     1'b0);
      chk({tag, "_shift_en"}, shift_en, 1'b0);
      chk({tag, "_sout"},     sout,     1'b0);
      chk({tag, "_done"},     done,     exp_done);
      chk({tag, "_s_ready"},  s_ready,  1'b1);
   endtask

   // seq_m / seq_l list the expected emitted bits, first bit in bit 7.
   task automatic run_frame(input string tag, input logic [7:0] w,
                            input logic [7:0] seq_m, input logic [7:0] seq_l,
                            input logic par);
      s_valid = 1'b1;
      s_data  = w;
      #1;
      chk({tag, "_hs_ready"}, s_ready, 1'b1);
      adv();
      s_valid = 1'b0;
      s_data  = 8'h00;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk($sformatf("%s_sout_c%0d", tag, i + 1),   sout,     seq_m[7-i]);
         chk($sformatf("%s_soutl_c%0d", tag, i + 1),  sout_l,   seq_l[7-i]);
         chk($sformatf("%s_shen_c%0d", tag, i + 1),   shift_en, 1'b1);
         chk($sformatf("%s_busy_c%0d", tag, i + 1),   busy,     1'b1);
         chk($sformatf("%s_done_c%0d", tag, i + 1),   done,     1'b0);
         adv();
      end
      if (PAR_EN) begin
         #1;
         chk({tag, "_par_sout"},  sout,     par);
         chk({tag, "_par_soutl"}, sout_l,   par);
         chk({tag, "_par_shen"},  shift_en, 1'b1);
         chk({tag, "_par_done"},  done,     1'b0);
         adv();
      end
      #1;
      idle_chk({tag, "_end"}, 1'b1);
      chk({tag, "_end_done_l"}, done_l, 1'b1);
      adv();
      #1;
      chk({tag, "_post_done"}, done, 1'b0);
   endtask

   initial begin
      rst_n   = 1'b0;
      s_valid = 1'b1;
      s_data  = 8'hFF;
      abort   = 1'b0;
      adv();
      adv();
      #1;
      chk("rst_s_ready",  s_ready,  1'b0);
      chk("rst_busy",     busy,     1'b0);
      chk("rst_shift_en", shift_en, 1'b0);
      chk("rst_sout",     sout,     1'b0);
      chk("rst_done",     done,     1'b0);
      rst_n   = 1'b1;
      s_valid = 1'b0;
      adv();
      #1;
      idle_chk("post_rst", 1'b0);
      adv();

      run_frame("a5", 8'hA5, 8'hA5, 8'hA5, 1'b0);
      adv();
      run_frame("01", 8'h01, 8'h01, 8'h80, 1'b1);
      adv();
      run_frame("07", 8'h07, 8'h07, 8'hE0, 1'b1);
      adv();

      // Abort in cycle 4 of a frame, with a competing word offered.
      s_valid = 1'b1;
      s_data  = 8'hF0;
      adv();
      s_valid = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         #1;
         chk($sformatf("abt_sout_c%0d", i), sout, 1'b1);
         adv();
      end
      abort   = 1'b1;
      s_valid = 1'b1;
      s_data  = 8'hFF;
      #1;
      chk("abt_c4_shen",    shift_en, 1'b1);
      chk("abt_c4_s_ready", s_ready,  1'b0);
      adv();
      abort   = 1'b0;
      s_valid = 1'b0;
      #1;
      idle_chk("abt_c5", 1'b0);
      adv();
      #1;
      idle_chk("abt_c6", 1'b0);
      adv();

      // Back-to-back: s_valid held high across two words.
      s_valid = 1'b1;
      s_data  = 8'h3C;
      #1;
      chk("b2b_hs1_ready", s_ready, 1'b1);
      adv();
      s_data = 8'hC3;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk($sformatf("b2b_f1_sout_c%0d", i + 1), sout,    s_data[7-i] ^ 1'b1);
         chk($sformatf("b2b_f1_rdy_c%0d", i + 1),  s_ready, 1'b0);
         adv();
      end
      if (PAR_EN) begin
         #1;
         chk("b2b_f1_par", sout, 1'b0);
         adv();
      end
      #1;
      chk("b2b_done1",    done,    1'b1);
      chk("b2b_hs2_ready", s_ready, 1'b1);
      adv();
      s_valid = 1'b0;
      s_data  = 8'h00;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk($sformatf("b2b_f2_sout_c%0d", i + 1), sout, (i < 2 || i > 5) ? 1'b1 : 1'b0);
         chk($sformatf("b2b_f2_shen_c%0d", i + 1), shift_en, 1'b1);
         adv();
      end
      if (PAR_EN) begin
         #1;
         chk("b2b_f2_par", sout, 1'b0);
         adv();
      end
      #1;
      idle_chk("b2b_done2", 1'b1);
      adv();
      adv();

      // Reset asserted in cycle 3 of a frame.
      s_valid = 1'b1;
      s_data  = 8'hFF;
      adv();
      s_valid = 1'b0;
      for (int i = 1; i <= 2; i++) begin
         #1;
         chk($sformatf("rmid_sout_c%0d", i), sout, 1'b1);
         adv();
      end
      rst_n = 1'b0;
      #1;
      chk("rmid_c3_busy", busy, 1'b1);
      adv();
      rst_n = 1'b1;
      #1;
      idle_chk("rmid_c4", 1'b0);
      adv();
      #1;
      idle_chk("rmid_c5", 1'b0);
      adv();
      run_frame("post_rmid", 8'h01, 8'h01, 8'h80, 1'b1);
      adv();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
